mac_feeder: RTL and testbench
=============================

# mac_feeder

Operand sequencer and result collector that drives the `mac` accumulator from the upstream side. It buffers A and B operand streams in two internal FIFOs and accepts a job (mode, length). It configures the MAC, streams exactly `job_len` contiguous operand pairs, and counts the MAC's `out_valid` pulses. It then returns the final accumulated value on a valid/ready result port.

## Interface
- `DEPTH`, 16, entries per operand FIFO; power of 2, ≥2, ≤255.
- `TIMEOUT`, 64, DRAIN watchdog limit in cycles; used only with `MAC_FEEDER_TIMEOUT_EN`.
- `clk` in 1: single clock; all logic on posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `job_start` in 1: job request; sampled only in IDLE.
- `job_float` in 1: 1 = fp16 job, 0 = int8 job.
- `job_len` in 8: number of operand pairs in the job.
- `busy` out 1: high whenever the state is not IDLE.
- `a_push_valid` in 1, `a_push_data` in 16, `a_push_ready` out 1: A FIFO write port.
- `b_push_valid` in 1, `b_push_data` in 16, `b_push_ready` out 1: B FIFO write port.
- `mac_in_a`, `mac_in_b` out 16: operands to the MAC.
- `mac_valid_a`, `mac_valid_b` out 1: operand valids to the MAC.
- `mac_config_en` out 1, `mac_float_int` out 1, `mac_data_num` out 8: MAC configuration outputs.
- `mac_out_valid` in 1, `mac_out` in 16: MAC result inputs.
- `res_valid` out 1, `res_data` out 16, `res_err` out 1, `res_ready` in 1: job result port.

## Operation
- **Reset state.** Both FIFOs are empty and the state is IDLE. All outputs are 0, except `a_push_ready` and `b_push_ready`, which are 1.
- **FIFO handshake.**
  - A push happens on `*_push_valid && *_push_ready`.
  - `*_push_ready = !full`, computed from the registered count. A full FIFO refuses a push even in a cycle where it pops.
  - A push and a pop in the same cycle on a non-full FIFO leaves the count unchanged.
  - Pointers wrap modulo DEPTH.
- **Job acceptance.** In IDLE, `job_start=1` latches `job_float` into `mode` and `job_len` into `len`.
  - If `len` is 0 or greater than DEPTH, the job is rejected: go to DONE with `res_err=1` and `res_data=0`. No MAC activity occurs.
  - Otherwise go to CONF.
- **`job_start` outside IDLE** is ignored.
- **`mac_float_int`** equals `mode` from acceptance until the return to IDLE. It is 0 in IDLE.
- **States:**
  - **IDLE:** wait for `job_start`.
  - **CONF:** lasts exactly 2 cycles. `mac_config_en=1` and `mac_data_num=len` in both cycles, then go to FILL. `mac_data_num` is 0 outside CONF.
  - **FILL:** wait until both FIFO counts are ≥ `len`, then go to STREAM. Filling first guarantees the stream is gap-free; the MAC clears its accumulator on any gap.
  - **STREAM:** lasts `len` cycles.
    - `mac_valid_a` and `mac_valid_b` are both 1.
    - `mac_in_a` and `mac_in_b` are the FIFO heads.
    - One entry is popped from each FIFO per cycle.
    - An issue counter counts to `len`, then the state goes to DRAIN.
    - `mac_in_*` is 0 whenever the valids are low.
  - **DRAIN:** wait until the result counter equals `len`, then go to DONE.
  - **DONE:** hold `res_valid=1` with stable `res_data` and `res_err` until `res_ready`, then go to IDLE. On that exit `res_valid` clears and the counters clear.
- **Result counter.**
  - Increments on each `mac_out_valid` seen in STREAM or DRAIN.
  - When it reaches `len`, `mac_out` is latched into `res_data` at that edge.
  - `mac_out_valid` in any other state is ignored.
- **Arithmetic.** No arithmetic is done on the data. Operands pass through unchanged; in int mode only bits [7:0] are meaningful to the MAC, and the full 16 bits are forwarded anyway.

## Timing
- Job accepted at edge E0 with both FIFOs already holding ≥N entries:
  - `mac_config_en` is high for cycles E0–E2.
  - FILL is at E2 and exits at E3.
  - The valids are high for N cycles, E3 to E3+N.
  - The final `mac_out_valid` is sampled at E3+N+1.
  - `res_valid` rises at E3+N+2.
  - Accept-to-`res_valid` latency is N+5 cycles.
- Every output is a register output; nothing combinational reaches the MAC.
- The `res_ready` handshake completes in the same cycle `res_valid` is high. A new job can be accepted on the following edge.
- Reset mid-job: all state returns to the reset values asynchronously. Buffered operands are discarded.

## Configuration
- **`MAC_FEEDER_TIMEOUT_EN` defined:**
  - DRAIN counts cycles.
  - If the result counter has not reached `len` after TIMEOUT cycles in DRAIN, go to DONE with `res_err=1` and `res_data=0`.
  - A late `mac_out_valid` is then ignored.
- **Not defined:** DRAIN waits indefinitely, and `res_err` is set only by rejection.

## Test plan
- **Int job.** Preload A={1,2,3}, B={4,5,6}; job len=3, float=0 → config_en high 2 cycles with data_num=3, valids high exactly 3 cycles, `res_data`=32, `res_err`=0.
- **Fill wait.** Start a job with len=4 while FIFOs hold 2 entries; push the rest 5 cycles later → no valid pulse before both counts are ≥4, then 4 contiguous valids.
- **Rejection.** job len=0, then len=DEPTH+1 → DONE immediately each time with `res_err`=1, `res_data`=0, no config_en pulse.
- **FIFO full.** Push DEPTH+1 entries into A → `a_push_ready`=0 after DEPTH entries, extra push dropped; push and pop in the same cycle at count 5 keeps the count at 5.
- **Backpressure and reset.** Hold `res_ready`=0 for 10 cycles → `res_valid`/`res_data` stable, `job_start` ignored. Assert `rst_n` low mid-STREAM → all outputs 0 and FIFOs empty immediately.
- **Timeout (`MAC_FEEDER_TIMEOUT_EN`).** Suppress `mac_out_valid` → `res_err`=1 exactly TIMEOUT cycles after entering DRAIN.

Source files
------------

// File: rtl/mac_feeder.sv
// mac_feeder: operand sequencer and result collector for the mac accumulator.
// Buffers A/B operand streams in two FIFOs, configures the MAC for a job,
// streams exactly len contiguous operand pairs, counts the MAC's out_valid
// pulses and returns the final accumulated value on a valid/ready port.
//
// Optional build macro: MAC_FEEDER_TIMEOUT_EN
//   When defined, DRAIN is guarded by a TIMEOUT-cycle watchdog that ends the
//   job with res_err=1 and res_data=0 if the MAC never delivers len results.
//
// State table:
//   S_IDLE   | waiting for job_start; all MAC-facing outputs low
//   S_CONF   | two cycles of mac_config_en with mac_data_num=len
//   S_FILL   | waiting until both FIFOs hold at least len operands
//   S_STREAM | one operand pair per cycle to the MAC, len cycles, no gaps
//   S_DRAIN  | waiting for the result counter to reach len
//   S_DONE   | result presented on res_*, held until res_ready

module mac_feeder_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_valid,
  input  logic [15:0]                push_data,
  output logic                       push_ready,
  input  logic                       pop,
  output logic [15:0]                head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ready_q, ready_d;
  logic          push_en;
  logic          pop_en;

  // A full FIFO refuses pushes even while popping, because ready is registered.
  assign push_en    = push_valid && ready_q;
  assign pop_en     = pop && (count_q != '0);
  assign push_ready = ready_q;
  assign head       = mem[rd_ptr_q];
  assign count      = count_q;

  // Pointer/count next-state; DEPTH is a power of 2 so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_en)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    ready_d = (count_d != CW'(DEPTH));
  end

  // Pointer, count and ready registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
    end
  end

  // Storage array; contents are don't-care once the count is cleared.
  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr_q] <= push_data;
  end

endmodule

module mac_feeder #(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        job_start,
  input  logic        job_float,
  input  logic [7:0]  job_len,
  output logic        busy,
  input  logic        a_push_valid,
  input  logic [15:0] a_push_data,
  output logic        a_push_ready,
  input  logic        b_push_valid,
  input  logic [15:0] b_push_data,
  output logic        b_push_ready,
  output logic [15:0] mac_in_a,
  output logic [15:0] mac_in_b,
  output logic        mac_valid_a,
  output logic        mac_valid_b,
  output logic        mac_config_en,
  output logic        mac_float_int,
  output logic [7:0]  mac_data_num,
  input  logic        mac_out_valid,
  input  logic [15:0] mac_out,
  output logic        res_valid,
  output logic [15:0] res_data,
  output logic        res_err,
  input  logic        res_ready
);

  localparam int         CW      = $clog2(DEPTH + 1);
  localparam logic [7:0] DEPTH_L = 8'(DEPTH);

  if (DEPTH < 2 || DEPTH > 255 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("mac_feeder: DEPTH must be a power of 2 in [2,255]");
  end
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("mac_feeder: TIMEOUT must be in [1,65535]");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONF,
    S_FILL,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic          mode_q, mode_d;
  logic [7:0]    len_q, len_d;
  logic          conf_cnt_q, conf_cnt_d;
  logic [7:0]    issue_q, issue_d;
  logic [7:0]    res_cnt_q, res_cnt_d;
`ifdef MAC_FEEDER_TIMEOUT_EN
  logic [15:0]   timer_q, timer_d;
`endif

  logic          busy_q, busy_d;
  logic [15:0]   in_a_q, in_a_d;
  logic [15:0]   in_b_q, in_b_d;
  logic          valid_q, valid_d;
  logic          config_en_q, config_en_d;
  logic          float_int_q, float_int_d;
  logic [7:0]    data_num_q, data_num_d;
  logic          res_valid_q, res_valid_d;
  logic [15:0]   res_data_q, res_data_d;
  logic          res_err_q, res_err_d;

  logic          pop;
  logic [15:0]   a_head, b_head;
  logic [CW-1:0] a_count, b_count;
  logic          fifos_ready;

  mac_feeder_fifo #(.DEPTH(DEPTH)) u_fifo_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (a_push_valid),
    .push_data  (a_push_data),
    .push_ready (a_push_ready),
    .pop        (pop),
    .head       (a_head),
    .count      (a_count)
  );

  mac_feeder_fifo #(.DEPTH(DEPTH)) u_fifo_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (b_push_valid),
    .push_data  (b_push_data),
    .push_ready (b_push_ready),
    .pop        (pop),
    .head       (b_head),
    .count      (b_count)
  );

  // Streaming only starts with the whole job buffered, so the MAC never sees a gap.
  assign fifos_ready = (8'(a_count) >= len_q) && (8'(b_count) >= len_q);

  assign busy          = busy_q;
  assign mac_in_a      = in_a_q;
  assign mac_in_b      = in_b_q;
  assign mac_valid_a   = valid_q;
  assign mac_valid_b   = valid_q;
  assign mac_config_en = config_en_q;
  assign mac_float_int = float_int_q;
  assign mac_data_num  = data_num_q;
  assign res_valid     = res_valid_q;
  assign res_data      = res_data_q;
  assign res_err       = res_err_q;

  // Next-state, counters, and registered-output values derived from the next state.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    len_d      = len_q;
    conf_cnt_d = conf_cnt_q;
    issue_d    = issue_q;
    res_cnt_d  = res_cnt_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    pop        = 1'b0;
`ifdef MAC_FEEDER_TIMEOUT_EN
    timer_d    = timer_q;
`endif

    // Result pulses only count while operands are in flight; saturate at len.
    if ((state_q == S_STREAM || state_q == S_DRAIN) && mac_out_valid &&
        (res_cnt_q != len_q)) begin
      res_cnt_d = res_cnt_q + 8'd1;
      if (res_cnt_q + 8'd1 == len_q) res_data_d = mac_out;
    end

    case (state_q)
      S_IDLE: begin
        if (job_start) begin
          mode_d     = job_float;
          len_d      = job_len;
          res_data_d = 16'd0;
          conf_cnt_d = 1'b0;
          if (job_len == 8'd0 || job_len > DEPTH_L) begin
            res_err_d = 1'b1;
            state_d   = S_DONE;
          end else begin
            res_err_d = 1'b0;
            state_d   = S_CONF;
          end
        end
      end
      S_CONF: begin
        if (conf_cnt_q) begin
          conf_cnt_d = 1'b0;
          state_d    = S_FILL;
        end else begin
          conf_cnt_d = 1'b1;
        end
      end
      S_FILL: begin
        if (fifos_ready) begin
          pop     = 1'b1;
          issue_d = 8'd1;
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (issue_q == len_q) begin
          state_d = S_DRAIN;
`ifdef MAC_FEEDER_TIMEOUT_EN
          timer_d = 16'(TIMEOUT - 1);
`endif
        end else begin
          pop     = 1'b1;
          issue_d = issue_q + 8'd1;
        end
      end
      S_DRAIN: begin
        if (res_cnt_q == len_q) begin
          state_d = S_DONE;
        end
`ifdef MAC_FEEDER_TIMEOUT_EN
        else if (timer_q == 16'd0) begin
          state_d    = S_DONE;
          res_err_d  = 1'b1;
          res_data_d = 16'd0;
        end else begin
          timer_d = timer_q - 16'd1;
        end
`endif
      end
      S_DONE: begin
        if (res_ready) begin
          state_d    = S_IDLE;
          mode_d     = 1'b0;
          len_d      = 8'd0;
          issue_d    = 8'd0;
          res_cnt_d  = 8'd0;
          res_data_d = 16'd0;
          res_err_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d      = (state_d != S_IDLE);
    valid_d     = pop;
    in_a_d      = pop ? a_head : 16'd0;
    in_b_d      = pop ? b_head : 16'd0;
    config_en_d = (state_d == S_CONF);
    data_num_d  = (state_d == S_CONF) ? len_d : 8'd0;
    float_int_d = (state_d != S_IDLE) ? mode_d : 1'b0;
    res_valid_d = (state_d == S_DONE);
  end

  // State, counter and output registers; everything the MAC sees comes from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mode_q      <= 1'b0;
      len_q       <= 8'd0;
      conf_cnt_q  <= 1'b0;
      issue_q     <= 8'd0;
      res_cnt_q   <= 8'd0;
`ifdef MAC_FEEDER_TIMEOUT_EN
      timer_q     <= 16'd0;
`endif
      busy_q      <= 1'b0;
      in_a_q      <= 16'd0;
      in_b_q      <= 16'd0;
      valid_q     <= 1'b0;
      config_en_q <= 1'b0;
      float_int_q <= 1'b0;
      data_num_q  <= 8'd0;
      res_valid_q <= 1'b0;
      res_data_q  <= 16'd0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      len_q       <= len_d;
      conf_cnt_q  <= conf_cnt_d;
      issue_q     <= issue_d;
      res_cnt_q   <= res_cnt_d;
`ifdef MAC_FEEDER_TIMEOUT_EN
      timer_q     <= timer_d;
`endif
      busy_q      <= busy_d;
      in_a_q      <= in_a_d;
      in_b_q      <= in_b_d;
      valid_q     <= valid_d;
      config_en_q <= config_en_d;
      float_int_q <= float_int_d;
      data_num_q  <= data_num_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
    end
  end

endmodule

// File: tb/tb_mac_feeder.sv
// Self-checking bench for mac_feeder: table-driven jobs plus hand-written
// sequences for fill wait, backpressure, FIFO full/push-pop, reset and timeout.
module tb_mac_feeder;

  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 64;

  logic        clk;
  logic        rst_n;
  logic        job_start;
  logic        job_float;
  logic [7:0]  job_len;
  logic        busy;
  logic        a_push_valid;
  logic [15:0] a_push_data;
  logic        a_push_ready;
  logic        b_push_valid;
  logic [15:0] b_push_data;
  logic        b_push_ready;
  logic [15:0] mac_in_a;
  logic [15:0] mac_in_b;
  logic        mac_valid_a;
  logic        mac_valid_b;
  logic        mac_config_en;
  logic        mac_float_int;
  logic [7:0]  mac_data_num;
  logic        mac_out_valid;
  logic [15:0] mac_out;
  logic        res_valid;
  logic [15:0] res_data;
  logic        res_err;
  logic        res_ready;

  mac_feeder #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .job_start     (job_start),
    .job_float     (job_float),
    .job_len       (job_len),
    .busy          (busy),
    .a_push_valid  (a_push_valid),
    .a_push_data   (a_push_data),
    .a_push_ready  (a_push_ready),
    .b_push_valid  (b_push_valid),
    .b_push_data   (b_push_data),
    .b_push_ready  (b_push_ready),
    .mac_in_a      (mac_in_a),
    .mac_in_b      (mac_in_b),
    .mac_valid_a   (mac_valid_a),
    .mac_valid_b   (mac_valid_b),
    .mac_config_en (mac_config_en),
    .mac_float_int (mac_float_int),
    .mac_data_num  (mac_data_num),
    .mac_out_valid (mac_out_valid),
    .mac_out       (mac_out),
    .res_valid     (res_valid),
    .res_data      (res_data),
    .res_err       (res_err),
    .res_ready     (res_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Simple MAC model: one-cycle registered running sum of low-byte products,
  // cleared by config and restarted after any gap in the operand stream.
  logic        mac_mute = 1'b0;
  logic [15:0] acc;
  logic        prev_in_v;
  logic [15:0] prod;
  assign prod = {8'd0, mac_in_a[7:0]} * {8'd0, mac_in_b[7:0]};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc           <= 16'd0;
      prev_in_v     <= 1'b0;
      mac_out_valid <= 1'b0;
      mac_out       <= 16'd0;
    end else begin
      mac_out_valid <= 1'b0;
      prev_in_v     <= mac_valid_a && mac_valid_b;
      if (mac_config_en) begin
        acc <= 16'd0;
      end else if (mac_valid_a && mac_valid_b) begin
        acc           <= (prev_in_v ? acc : 16'd0) + prod;
        mac_out       <= (prev_in_v ? acc : 16'd0) + prod;
        mac_out_valid <= !mac_mute;
      end
    end
  end

  // Output monitor sampled on the falling edge; counters only accumulate.
  int          cfg_cnt = 0, vld_cnt = 0, runs = 0;
  int          bad_num = 0, bad_float = 0, bad_zero = 0, bad_idle = 0;
  logic [15:0] last_a = 16'd0;
  logic        prev_mon_v = 1'b0;
  logic [7:0]  mon_len = 8'd0;
  logic        mon_float = 1'b0;

  always @(negedge clk) begin
    if (mac_config_en) begin
      cfg_cnt++;
      if (mac_data_num != mon_len) bad_num++;
      if (mac_float_int != mon_float) bad_float++;
    end
    if (mac_valid_a) begin
      vld_cnt++;
      last_a = mac_in_a;
      if (!prev_mon_v) runs++;
    end
    if (mac_valid_a != mac_valid_b) bad_zero++;
    if (!mac_valid_a && (mac_in_a != 16'd0 || mac_in_b != 16'd0)) bad_zero++;
    if (!busy && (mac_float_int || mac_config_en || mac_valid_a || mac_data_num != 8'd0)) bad_idle++;
    prev_mon_v = mac_valid_a;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic push(input bit da, input bit db, input int n,
                      input logic [15:0] a0, input logic [15:0] as,
                      input logic [15:0] b0, input logic [15:0] bs);
    for (int i = 0; i < n; i++) begin
      a_push_valid = da;
      b_push_valid = db;
      a_push_data  = a0 + 16'(i) * as;
      b_push_data  = b0 + 16'(i) * bs;
      @(posedge clk); #1;
    end
    a_push_valid = 1'b0;
    b_push_valid = 1'b0;
  endtask

  // Drives a request for one edge; returns 1ns after the acceptance edge.
  task automatic start_job(input logic flt, input logic [7:0] len);
    job_start = 1'b1;
    job_float = flt;
    job_len   = len;
    mon_len   = len;
    mon_float = flt;
    @(posedge clk); #1;
    job_start = 1'b0;
  endtask

  task automatic wait_res(output int lat);
    lat = 0;
    while (!res_valid && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_res(input string name);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk({name, "_released"}, {30'd0, res_valid, busy}, 32'd0);
  endtask

  typedef struct {
    logic        flt;
    logic [7:0]  len;
    logic [15:0] a0, as, b0, bs;
    logic [15:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int lat, cfg0, vld0, runs0, acc_n, k;
    logic [15:0] hold_data;

    vecs[0] = '{1'b0, 8'd3,   16'd1,      16'd1, 16'd4,  16'd1,  16'd32,  1'b0};
    vecs[1] = '{1'b1, 8'd2,   16'd2,      16'd1, 16'd5,  16'd2,  16'd31,  1'b0};
    vecs[2] = '{1'b0, 8'd1,   16'h1209,   16'd0, 16'd3,  16'd0,  16'd27,  1'b0};
    vecs[3] = '{1'b0, 8'd4,   16'd1,      16'd0, 16'd10, 16'd10, 16'd100, 1'b0};
    vecs[4] = '{1'b0, 8'd0,   16'd0,      16'd0, 16'd0,  16'd0,  16'd0,   1'b1};
    vecs[5] = '{1'b0, 8'd17,  16'd0,      16'd0, 16'd0,  16'd0,  16'd0,   1'b1};
    vecs[6] = '{1'b1, 8'd255, 16'd0,      16'd0, 16'd0,  16'd0,  16'd0,   1'b1};

    rst_n = 1'b0; job_start = 1'b0; job_float = 1'b0; job_len = 8'd0;
    a_push_valid = 1'b0; a_push_data = 16'd0; b_push_valid = 1'b0; b_push_data = 16'd0;
    res_ready = 1'b0;
    #12;
    chk("reset_flags", {23'd0, a_push_ready, b_push_ready, busy, res_valid, res_err,
                        mac_valid_a, mac_valid_b, mac_config_en, mac_float_int}, 32'h180);
    chk("reset_data", {16'd0, res_data | mac_in_a | mac_in_b | {8'd0, mac_data_num}}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 7; v++) begin
      if (!vecs[v].exp_err)
        push(1'b1, 1'b1, int'(vecs[v].len), vecs[v].a0, vecs[v].as, vecs[v].b0, vecs[v].bs);
      cfg0 = cfg_cnt; vld0 = vld_cnt; runs0 = runs;
      start_job(vecs[v].flt, vecs[v].len);
      wait_res(lat);
      chk($sformatf("vec%0d_res_data", v), {16'd0, res_data}, {16'd0, vecs[v].exp_data});
      chk($sformatf("vec%0d_res_err", v), {31'd0, res_err}, {31'd0, vecs[v].exp_err});
      chk($sformatf("vec%0d_latency", v), lat, vecs[v].exp_err ? 0 : int'(vecs[v].len) + 5);
      chk($sformatf("vec%0d_cfg_cycles", v), cfg_cnt - cfg0, vecs[v].exp_err ? 0 : 2);
      chk($sformatf("vec%0d_valid_cycles", v), vld_cnt - vld0, vecs[v].exp_err ? 0 : int'(vecs[v].len));
      chk($sformatf("vec%0d_valid_runs", v), runs - runs0, vecs[v].exp_err ? 0 : 1);
      if (!vecs[v].exp_err)
        chk($sformatf("vec%0d_last_a", v), {16'd0, last_a},
            {16'd0, vecs[v].a0 + 16'(vecs[v].len - 8'd1) * vecs[v].as});
      chk($sformatf("vec%0d_float_int", v), {31'd0, mac_float_int}, {31'd0, vecs[v].flt});
      release_res($sformatf("vec%0d", v));
    end

    // Fill wait: only half the operands are present when the job starts.
    push(1'b1, 1'b1, 2, 16'd1, 16'd1, 16'd1, 16'd0);
    vld0 = vld_cnt; runs0 = runs;
    start_job(1'b0, 8'd4);
    repeat (5) @(posedge clk);
    #1;
    chk("fill_no_early_valid", vld_cnt - vld0, 0);
    chk("fill_busy", {31'd0, busy}, 32'd1);
    push(1'b1, 1'b1, 2, 16'd3, 16'd1, 16'd1, 16'd0);
    wait_res(lat);
    chk("fill_valid_cycles", vld_cnt - vld0, 4);
    chk("fill_valid_runs", runs - runs0, 1);
    chk("fill_res_data", {16'd0, res_data}, 32'd10);
    release_res("fill");

    // Backpressure: result held stable, job_start ignored while in DONE.
    push(1'b1, 1'b1, 2, 16'd3, 16'd1, 16'd2, 16'd0);
    start_job(1'b0, 8'd2);
    wait_res(lat);
    hold_data = res_data;
    chk("bp_res_data", {16'd0, hold_data}, 32'd14);
    cfg0 = cfg_cnt;
    for (int i = 0; i < 10; i++) begin
      job_start = 1'b1; job_len = 8'd1;
      @(posedge clk); #1;
      chk($sformatf("bp_hold_valid_%0d", i), {31'd0, res_valid}, 32'd1);
      chk($sformatf("bp_hold_data_%0d", i), {16'd0, res_data}, {16'd0, hold_data});
    end
    job_start = 1'b0;
    chk("bp_no_config", cfg_cnt - cfg0, 0);
    release_res("bp");

    // Push and pop in the same cycle at count 5, then fill A to full.
    push(1'b1, 1'b0, 5, 16'd2, 16'd0, 16'd0, 16'd0);
    push(1'b0, 1'b1, 1, 16'd0, 16'd0, 16'd7, 16'd0);
    start_job(1'b0, 8'd1);
    @(posedge clk);
    @(posedge clk); #1;
    a_push_valid = 1'b1; a_push_data = 16'd9;
    @(posedge clk); #1;
    a_push_valid = 1'b0;
    wait_res(lat);
    chk("pushpop_res_data", {16'd0, res_data}, 32'd14);
    release_res("pushpop");
    acc_n = 0;
    for (int i = 0; i < 20; i++) begin
      a_push_valid = 1'b1; a_push_data = 16'(50 + i);
      if (a_push_ready) acc_n++;
      @(posedge clk); #1;
    end
    a_push_valid = 1'b0;
    chk("pushpop_room_left", acc_n, DEPTH - 5);
    chk("pushpop_full_ready", {31'd0, a_push_ready}, 32'd0);

    rst_n = 1'b0; #2; rst_n = 1'b1;
    @(posedge clk); #1;

    // DEPTH+1 pushes: the extra one must be dropped, not overwrite an entry.
    acc_n = 0;
    for (int i = 0; i <= DEPTH; i++) begin
      a_push_valid = 1'b1; a_push_data = (i < DEPTH) ? 16'(i + 1) : 16'd100;
      if (a_push_ready) acc_n++;
      @(posedge clk); #1;
    end
    a_push_valid = 1'b0;
    chk("full_accepted", acc_n, DEPTH);
    chk("full_ready_low", {31'd0, a_push_ready}, 32'd0);
    push(1'b0, 1'b1, DEPTH, 16'd0, 16'd0, 16'd1, 16'd0);
    start_job(1'b0, 8'(DEPTH));
    wait_res(lat);
    chk("full_latency", lat, DEPTH + 5);
    chk("full_res_data", {16'd0, res_data}, 32'd136);
    release_res("full");

    // Reset in the middle of STREAM.
    push(1'b1, 1'b1, 8, 16'd9, 16'd0, 16'd9, 16'd0);
    start_job(1'b0, 8'd8);
    k = 0;
    while (!mac_valid_a && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("midrst_streaming", {31'd0, mac_valid_a}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_flags", {23'd0, a_push_ready, b_push_ready, busy, res_valid, res_err,
                         mac_valid_a, mac_valid_b, mac_config_en, mac_float_int}, 32'h180);
    chk("midrst_data", {16'd0, res_data | mac_in_a | mac_in_b | {8'd0, mac_data_num}}, 32'd0);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    push(1'b1, 1'b1, 1, 16'd5, 16'd0, 16'd5, 16'd0);
    start_job(1'b0, 8'd1);
    wait_res(lat);
    chk("midrst_fifo_empty_res", {16'd0, res_data}, 32'd25);
    release_res("midrst");

`ifdef MAC_FEEDER_TIMEOUT_EN
    mac_mute = 1'b1;
    push(1'b1, 1'b1, 2, 16'd1, 16'd0, 16'd1, 16'd0);
    start_job(1'b0, 8'd2);
    wait_res(lat);
    chk("timeout_latency", lat, 2 + 3 + TIMEOUT);
    chk("timeout_res_err", {31'd0, res_err}, 32'd1);
    chk("timeout_res_data", {16'd0, res_data}, 32'd0);
    release_res("timeout");
    mac_mute = 1'b0;
`endif

    chk("mon_data_num", bad_num, 0);
    chk("mon_float_int", bad_float, 0);
    chk("mon_valid_zero", bad_zero, 0);
    chk("mon_idle_quiet", bad_idle, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
